// File: rtl/clk_div_prog.sv
// Programmable clock divider with glitch-free divisor changes applied only at period boundaries.
// Define CLK_DIV_PROG_PERIOD_CNT_EN to add the 16-bit period_cnt output.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_pending,
  output logic             clk_out,
  output logic             tick
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] div_cur_q, div_cur_d;
  logic [WIDTH-1:0] div_nxt_q, div_nxt_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             wrap;
  logic             wr;
  logic [WIDTH-1:0] div_clamped;

  assign div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;
  // Writes are ignored while disabled so that every piece of state holds.
  assign wr   = en && div_wr;
  assign wrap = en && (counter_q == div_cur_q - ONE);

  // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
  always_comb begin
    counter_d = counter_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = wrap;

    if (en) begin
      counter_d = wrap ? '0 : counter_q + ONE;
      if (wrap) begin
        // A write landing on the wrap beats any older pending divisor.
        if (wr) begin
          div_cur_d = div_clamped;
        end else if (pending_q) begin
          div_cur_d = div_nxt_q;
        end
        pending_d = 1'b0;
      end else if (wr) begin
        div_nxt_d = div_clamped;
        pending_d = 1'b1;
      end
      clk_out_d = (counter_d < (div_cur_d >> 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      counter_q <= '0;
      div_cur_q <= DEF_DIV;
      div_nxt_q <= DEF_DIV;
      pending_q <= 1'b0;
      clk_out_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign div_pending = pending_q;
  assign clk_out     = clk_out_q;
  assign tick        = tick_q;

`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
  logic [15:0] period_cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      period_cnt_q <= '0;
    end else if (tick_q) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=4); expected values are hand-computed
// per cycle. Outputs are sampled 1 ns after each rising edge.
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       div_wr;
  logic [7:0] div_val;
  logic       div_pending;
  logic       clk_out;
  logic       tick;
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .en          (en),
    .div_wr      (div_wr),
    .div_val     (div_val),
    .div_pending (div_pending),
    .clk_out     (clk_out),
    .tick        (tick)
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    ,
    .period_cnt  (period_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then compare clk_out / tick / div_pending.
  task automatic cyc(input logic e_clk, input logic e_tick, input logic e_pend, input string tag);
    step();
    chk({15'd0, clk_out},     {15'd0, e_clk},  {tag, " clk_out"});
    chk({15'd0, tick},        {15'd0, e_tick}, {tag, " tick"});
    chk({15'd0, div_pending}, {15'd0, e_pend}, {tag, " pending"});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div_wr = 1'b0; div_val = 8'd0;
    step();
    cyc(1, 0, 0, "reset");
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    chk(period_cnt, 16'd0, "reset period_cnt");
`endif

    // Default divisor 4: 1,1,0,0 with tick at every count 0 after a wrap.
    rst = 1'b0; en = 1'b1;
    cyc(1, 0, 0, "d4 c1");
    cyc(0, 0, 0, "d4 c2");
    cyc(0, 0, 0, "d4 c3");
    cyc(1, 1, 0, "d4 c0 wrap1");
    cyc(1, 0, 0, "d4 c1 b");
    cyc(0, 0, 0, "d4 c2 b");
    cyc(0, 0, 0, "d4 c3 b");
    cyc(1, 1, 0, "d4 c0 wrap2");
    cyc(1, 0, 0, "d4 c1 c");
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    chk(period_cnt, 16'd2, "period_cnt after two ticks");
`endif

    // Write 5 at count 1: period of 4 completes, then 2 high / 3 low.
    div_wr = 1'b1; div_val = 8'd5;
    cyc(0, 0, 1, "w5 c2");
    div_wr = 1'b0;
    cyc(0, 0, 1, "w5 c3");
    cyc(1, 1, 0, "d5 c0 applied");
    cyc(1, 0, 0, "d5 c1");
    cyc(0, 0, 0, "d5 c2");
    cyc(0, 0, 0, "d5 c3");
    cyc(0, 0, 0, "d5 c4");
    cyc(1, 1, 0, "d5 c0 wrap");

    // Write 0 clamps to 2: toggles each cycle, tick every 2.
    div_wr = 1'b1; div_val = 8'd0;
    cyc(1, 0, 1, "w0 c1");
    div_wr = 1'b0;
    cyc(0, 0, 1, "w0 c2");
    cyc(0, 0, 1, "w0 c3");
    cyc(0, 0, 1, "w0 c4");
    cyc(1, 1, 0, "d2 c0 applied");
    cyc(0, 0, 0, "d2 c1");
    cyc(1, 1, 0, "d2 c0 a");
    cyc(0, 0, 0, "d2 c1 b");
    cyc(1, 1, 0, "d2 c0 b");

    // Move to 6, then pause 3 cycles at count 2.
    div_wr = 1'b1; div_val = 8'd6;
    cyc(0, 0, 1, "w6 c1");
    div_wr = 1'b0;
    cyc(1, 1, 0, "d6 c0 applied");
    cyc(1, 0, 0, "d6 c1");
    cyc(1, 0, 0, "d6 c2");
    en = 1'b0;
    cyc(1, 0, 0, "hold 1");
    cyc(1, 0, 0, "hold 2");
    cyc(1, 0, 0, "hold 3");
    en = 1'b1;
    cyc(0, 0, 0, "resume c3");
    cyc(0, 0, 0, "resume c4");
    cyc(0, 0, 0, "resume c5");
    cyc(1, 1, 0, "resume wrap");

    // Pending 7, then write 3 on the wrap edge: 3 wins, 7 is dropped.
    div_wr = 1'b1; div_val = 8'd7;
    cyc(1, 0, 1, "w7 c1");
    div_wr = 1'b0;
    cyc(1, 0, 1, "w7 c2");
    cyc(0, 0, 1, "w7 c3");
    cyc(0, 0, 1, "w7 c4");
    cyc(0, 0, 1, "w7 c5");
    div_wr = 1'b1; div_val = 8'd3;
    cyc(1, 1, 0, "w3 on wrap");
    div_wr = 1'b0;
    cyc(0, 0, 0, "d3 c1");
    cyc(0, 0, 0, "d3 c2");
    cyc(1, 1, 0, "d3 c0 wrap");
    cyc(0, 0, 0, "d3 c1 b");
    cyc(0, 0, 0, "d3 c2 b");
    cyc(1, 1, 0, "d3 c0 wrap b");

    // Pending 9, then reset mid-period with a competing write: back to divisor 4.
    div_wr = 1'b1; div_val = 8'd9;
    cyc(0, 0, 1, "w9 c1");
    rst = 1'b1; div_val = 8'd5;
    cyc(1, 0, 0, "mid reset");
`ifdef CLK_DIV_PROG_PERIOD_CNT_EN
    chk(period_cnt, 16'd0, "mid reset period_cnt");
`endif
    rst = 1'b0; div_wr = 1'b0;
    cyc(1, 0, 0, "post rst c1");
    cyc(0, 0, 0, "post rst c2");
    cyc(0, 0, 0, "post rst c3");
    cyc(1, 1, 0, "post rst wrap");
    cyc(1, 0, 0, "post rst c1 b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
